// File: rtl/board_loader.sv
// rtl/board_loader.sv - Latches edge/center tile orders, streams them to board memory, checks the layout
module board_loader #(
    parameter int EDGE_TILES   = 24,
    parameter int CENTER_TILES = 12,
    parameter int TILE_W       = 4,
    parameter int CENTER_BASE  = 32
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [EDGE_TILES*TILE_W-1:0]   edge_order,
    input  logic [CENTER_TILES*TILE_W-1:0] center_order,
    output logic                           wr_en,
    output logic [5:0]                     wr_addr,
    output logic [TILE_W-1:0]              wr_data,
    input  logic                           wr_ready,
    output logic                           busy,
    output logic                           done,
    output logic                           layout_ok,
    output logic                           err_range,
    output logic                           err_count
);
    localparam int NUM_CODES = 12;
    localparam int MAX_TILES = (EDGE_TILES > CENTER_TILES) ? EDGE_TILES : CENTER_TILES;
    localparam int IDX_W     = (MAX_TILES > 1) ? $clog2(MAX_TILES) : 1;

    localparam logic [TILE_W-1:0] MAX_CODE    = TILE_W'(NUM_CODES - 1);
    localparam logic [IDX_W-1:0]  EDGE_LAST   = IDX_W'(EDGE_TILES - 1);
    localparam logic [IDX_W-1:0]  CENTER_LAST = IDX_W'(CENTER_TILES - 1);
    localparam logic [5:0]        CENTER_ADDR = 6'(CENTER_BASE);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EDGE,
        S_CENTER,
        S_CHECK
    } state_t;

    state_t                         r_state;
    logic [IDX_W-1:0]               r_idx;
    logic [EDGE_TILES*TILE_W-1:0]   r_edge;
    logic [CENTER_TILES*TILE_W-1:0] r_center;
    logic [1:0]                     r_edge_cnt [NUM_CODES];
    logic [NUM_CODES-1:0]           r_center_seen;
    logic                           r_dup;
    logic                           r_range;

    logic                 w_accept;
    logic                 w_code_ok;
    logic [NUM_CODES-1:0] w_code_hit;
    logic [NUM_CODES-1:0] w_seen_next;
    logic                 w_dup_next;
    logic                 w_range_next;
    logic                 w_cnt_bad;
    logic                 w_err_count_final;
    logic [IDX_W-1:0]     w_idx_nxt;
    int                   w_sel_base;
    logic [TILE_W-1:0]    w_edge_tile_nxt;
    logic [TILE_W-1:0]    w_center_tile_nxt;

    // The code being written is whatever sits on wr_data, so the histogram follows the memory stream exactly.
    always_comb begin
        w_accept          = wr_en & wr_ready;
        w_code_ok         = (wr_data <= MAX_CODE);
        w_code_hit        = w_code_ok ? (NUM_CODES'(1) << wr_data) : '0;
        w_seen_next       = r_center_seen | w_code_hit;
        w_dup_next        = r_dup | (|(r_center_seen & w_code_hit));
        w_range_next      = r_range | ~w_code_ok;
        w_idx_nxt         = r_idx + IDX_W'(1);
        w_sel_base        = TILE_W * 32'(w_idx_nxt);
        w_edge_tile_nxt   = r_edge[w_sel_base +: TILE_W];
        w_center_tile_nxt = r_center[w_sel_base +: TILE_W];
    end

    always_comb begin
        w_cnt_bad = 1'b0;
        for (int k = 0; k < NUM_CODES; k++) begin
            if (r_edge_cnt[k] != 2'd2) begin
                w_cnt_bad = 1'b1;
            end
        end
        // Folds in the final center write, which lands on the same edge that enters CHECK.
        w_err_count_final = w_cnt_bad | w_dup_next | ~(&w_seen_next);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_idx         <= '0;
            r_center_seen <= '0;
            r_dup         <= 1'b0;
            r_range       <= 1'b0;
            for (int k = 0; k < NUM_CODES; k++) begin
                r_edge_cnt[k] <= 2'd0;
            end
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            layout_ok <= 1'b0;
            err_range <= 1'b0;
            err_count <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        r_edge        <= edge_order;
                        r_center      <= center_order;
                        r_idx         <= '0;
                        r_center_seen <= '0;
                        r_dup         <= 1'b0;
                        r_range       <= 1'b0;
                        for (int k = 0; k < NUM_CODES; k++) begin
                            r_edge_cnt[k] <= 2'd0;
                        end
                        layout_ok <= 1'b0;
                        err_range <= 1'b0;
                        err_count <= 1'b0;
                        wr_en     <= 1'b1;
                        wr_addr   <= '0;
                        wr_data   <= edge_order[TILE_W-1:0];
                        busy      <= 1'b1;
                        r_state   <= S_EDGE;
                    end
                end

                S_EDGE: begin
                    if (w_accept) begin
                        r_range <= w_range_next;
                        for (int k = 0; k < NUM_CODES; k++) begin
                            if (w_code_hit[k] && r_edge_cnt[k] != 2'd3) begin
                                r_edge_cnt[k] <= r_edge_cnt[k] + 2'd1;
                            end
                        end
                        if (r_idx == EDGE_LAST) begin
                            r_idx   <= '0;
                            wr_addr <= CENTER_ADDR;
                            wr_data <= r_center[TILE_W-1:0];
                            r_state <= S_CENTER;
                        end else begin
                            r_idx   <= w_idx_nxt;
                            wr_addr <= 6'(w_idx_nxt);
                            wr_data <= w_edge_tile_nxt;
                        end
                    end
                end

                S_CENTER: begin
                    if (w_accept) begin
                        r_center_seen <= w_seen_next;
                        r_dup         <= w_dup_next;
                        r_range       <= w_range_next;
                        if (r_idx == CENTER_LAST) begin
                            wr_en     <= 1'b0;
                            wr_addr   <= '0;
                            wr_data   <= '0;
                            done      <= 1'b1;
                            err_range <= w_range_next;
                            err_count <= w_err_count_final;
                            layout_ok <= ~(w_range_next | w_err_count_final);
                            r_state   <= S_CHECK;
                        end else begin
                            r_idx   <= w_idx_nxt;
                            wr_addr <= CENTER_ADDR + 6'(w_idx_nxt);
                            wr_data <= w_center_tile_nxt;
                        end
                    end
                end

                S_CHECK: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end
endmodule
